port_egress_buffer: RTL and testbench
=====================================

PORT_EGRESS_BUFFER -- requirements
Module: port_egress_buffer

Interface
REQ-001 Parameter: PORT_ID, 0, index (0..3) of the switch output port this buffer serves.
REQ-002 Parameter: DEPTH, 8, packet entries; power of two, 2..16.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 in_valid  input  1  packet present this cycle; driven from the switch valid_out; no backpressure toward the switch.
REQ-006 in_source  input  4  one-hot source port of the packet.
REQ-007 in_target  input  4  target port bitmask of the packet.
REQ-008 in_data  input  8  packet payload.
REQ-009 out_valid  output  1  head packet available to the consumer.
REQ-010 out_ready  input  1  consumer accepts the head packet when high with out_valid.
REQ-011 out_source / out_target / out_data  output  4/4/8  head packet fields.
REQ-012 level  output  5  number of stored packets, 0..DEPTH.
REQ-013 drop_cnt  output  16  packets lost because the buffer was full.
REQ-014 misroute_cnt  output  16  packets rejected as illegal for this port.
REQ-015 clr_cnt  input  1  synchronous clear of both counters.

Function
REQ-016 Legal packet: in_valid=1, in_source one-hot, in_target[PORT_ID]=1, and in_source[PORT_ID]=0.
REQ-017 An in_valid packet that is not legal SHALL NOT be stored, and misroute_cnt SHALL increment.
REQ-018 Pop occurs when out_valid and out_ready are both 1 at the rising edge.
REQ-019 A legal packet SHALL be stored when level<DEPTH, or when level=DEPTH and a pop occurs in the same cycle.
REQ-020 Otherwise a legal packet SHALL be discarded and drop_cnt SHALL increment; stored contents SHALL be unchanged.
REQ-021 Packets SHALL leave in arrival order, with fields bit-exact to the input.
REQ-022 Latency: a packet stored at edge N into an empty buffer SHALL drive out_valid=1 from edge N until its pop (one-cycle latency, first-word fall-through).
REQ-023 While out_valid=1 and out_ready=0, out_source, out_target and out_data SHALL hold stable.
REQ-024 When out_valid=0, out_source, out_target and out_data SHALL be 0.
REQ-025 FSM states: ST_EMPTY (level=0), ST_ACTIVE (0<level<DEPTH), ST_FULL (level=DEPTH).
REQ-026 ST_EMPTY->ST_ACTIVE on a store; ST_ACTIVE->ST_EMPTY on a pop without a store when level=1; ST_ACTIVE->ST_FULL on a store without a pop when level=DEPTH-1; ST_FULL->ST_ACTIVE on a pop without a store; any other case SHALL hold the state.
REQ-027 out_valid SHALL be 1 exactly when state is not ST_EMPTY.
REQ-028 Simultaneous store and pop SHALL leave level unchanged.
REQ-029 Read and write pointers SHALL wrap modulo DEPTH.
REQ-030 Counters SHALL saturate at 16'hFFFF.
REQ-031 clr_cnt=1 SHALL zero both counters at the edge, overriding any coincident increment.
REQ-032 At most one counter SHALL increment per cycle.

Reset
REQ-033 While rst_n=0 at the rising edge, the block SHALL reset to: state ST_EMPTY, pointers 0, level 0, out_valid 0, out fields 0, drop_cnt 0, misroute_cnt 0.
REQ-034 Reset SHALL discard stored packets, including during mid-stream operation.
REQ-035 Inputs SHALL be ignored in any cycle where rst_n=0.

Structure
REQ-036 Package switch_pkg SHALL contain NUM_PORTS=4, typedef pkt_t {src[3:0], tgt[3:0], dat[7:0]}, the egress FSM state enum, and the is_onehot4 function.
REQ-037 Storage SHALL be a sub-module egress_fifo (parameter DEPTH, push/pop/full/empty/level). Legality checks, the FSM, and the counters SHALL stay in port_egress_buffer.

Verification
REQ-038 PORT_ID=2, empty buffer, out_ready=1: at one edge, in_valid=1, src=4'b0001, tgt=4'b0100, data=8'hA5 -> after that edge, out_valid=1 with those fields; popped at the next edge; level returns to 0.
REQ-039 out_ready=0: push 10 legal packets with data 8'h00..8'h09 -> level=8, state ST_FULL, drop_cnt=2; then out_ready=1 -> data 8'h00..8'h07 output in order.
REQ-040 Packets src=4'b0011 tgt=4'b0100, src=4'b0100 tgt=4'b0100, and src=4'b0001 tgt=4'b0010 -> nothing stored, misroute_cnt=3.
REQ-041 Full buffer with out_ready=1 and a legal push at the same edge -> level stays 8, drop_cnt unchanged, order preserved across pointer wrap.
REQ-042 drop_cnt preset near 16'hFFFF -> saturates at 16'hFFFF; clr_cnt=1 coincident with a drop -> drop_cnt=0; rst_n=0 for one edge with level=5 -> level=0, out_valid=0.

Source files
------------

// File: rtl/switch_pkg.sv
// Shared types for the switch egress path: packet record, egress FSM states
// and a one-hot helper used by the legality check.
package switch_pkg;

    localparam int NUM_PORTS = 4;

    typedef struct packed {
        logic [3:0] src;
        logic [3:0] tgt;
        logic [7:0] dat;
    } pkt_t;

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_FULL   = 2'd2
    } egress_state_e;

    function automatic logic is_onehot4(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

endpackage

// File: rtl/egress_fifo.sv
// Packet storage for one egress port: first-word fall-through FIFO whose head
// entry is readable combinationally from the read pointer.
module egress_fifo #(
    parameter int DEPTH = 8,
    localparam int PW   = $clog2(DEPTH),
    localparam int LW   = PW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic [15:0]   din,
    output logic [15:0]   dout,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level
);

    logic [15:0]   mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LW-1:0] level_q;

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            if (push && !pop)      level_q <= level_q + LW'(1);
            else if (pop && !push) level_q <= level_q - LW'(1);
        end
    end

    // When full with a coincident pop, wr_ptr == rd_ptr: the head is consumed
    // at this edge, so overwriting its slot is safe.
    always_ff @(posedge clk) begin
        if (rst_n && push) mem_q[wr_ptr_q] <= din;
    end

    assign dout  = mem_q[rd_ptr_q];
    assign level = level_q;
    assign full  = (level_q == LW'(DEPTH));
    assign empty = (level_q == '0);

endmodule

// File: rtl/port_egress_buffer.sv
// Egress buffer for one switch output port: filters illegal packets, stores
// legal ones in arrival order and counts drops and misroutes.
module port_egress_buffer
    import switch_pkg::*;
#(
    parameter int PORT_ID = 0,
    parameter int DEPTH   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [3:0]  in_source,
    input  logic [3:0]  in_target,
    input  logic [7:0]  in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out_source,
    output logic [3:0]  out_target,
    output logic [7:0]  out_data,
    output logic [4:0]  level,
    output logic [15:0] drop_cnt,
    output logic [15:0] misroute_cnt,
    input  logic        clr_cnt
);

    localparam int LW = $clog2(DEPTH) + 1;

    egress_state_e state_q;
    logic [15:0]   drop_cnt_q, misroute_cnt_q;
    logic          legal, misroute, store, pop, drop;
    logic          fifo_full, fifo_empty;
    logic [LW-1:0] fifo_level;
    logic [15:0]   fifo_dout;
    pkt_t          in_pkt, head;

    assign legal    = in_valid && is_onehot4(in_source) && in_target[PORT_ID] && !in_source[PORT_ID];
    assign misroute = in_valid && !legal;
    assign pop      = out_valid && out_ready && !fifo_empty;
    assign store    = legal && (!fifo_full || pop);
    assign drop     = legal && !store;

    assign in_pkt = '{src: in_source, tgt: in_target, dat: in_data};

    egress_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (store),
        .pop   (pop),
        .din   (in_pkt),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY:  if (store) state_q <= ST_ACTIVE;
                ST_ACTIVE: begin
                    if (pop && !store && fifo_level == LW'(1))
                        state_q <= ST_EMPTY;
                    else if (store && !pop && fifo_level == LW'(DEPTH - 1))
                        state_q <= ST_FULL;
                end
                ST_FULL:   if (pop && !store) state_q <= ST_ACTIVE;
                default:   state_q <= ST_EMPTY;
            endcase
        end
    end

    // Drop and misroute are mutually exclusive, so at most one counter moves.
    always_ff @(posedge clk) begin
        if (!rst_n || clr_cnt) begin
            drop_cnt_q     <= '0;
            misroute_cnt_q <= '0;
        end else begin
            if (misroute && misroute_cnt_q != 16'hFFFF) misroute_cnt_q <= misroute_cnt_q + 16'd1;
            if (drop && drop_cnt_q != 16'hFFFF)         drop_cnt_q     <= drop_cnt_q + 16'd1;
        end
    end

    assign head         = pkt_t'(fifo_dout);
    assign out_valid    = (state_q != ST_EMPTY);
    assign out_source   = out_valid ? head.src : 4'd0;
    assign out_target   = out_valid ? head.tgt : 4'd0;
    assign out_data     = out_valid ? head.dat : 8'd0;
    assign level        = 5'(fifo_level);
    assign drop_cnt     = drop_cnt_q;
    assign misroute_cnt = misroute_cnt_q;

endmodule

// File: tb/tb_port_egress_buffer.sv
// Bench for port_egress_buffer (PORT_ID=2, DEPTH=8): directed table, corner
// sequences and random traffic against a queue-based reference model.
module tb_port_egress_buffer;
    import switch_pkg::*;

    localparam int PID = 2;
    localparam int DEP = 8;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, out_ready, clr_cnt;
    logic [3:0]  in_source, in_target;
    logic [7:0]  in_data;
    logic        out_valid;
    logic [3:0]  out_source, out_target;
    logic [7:0]  out_data;
    logic [4:0]  level;
    logic [15:0] drop_cnt, misroute_cnt;

    int checks = 0;
    int errors = 0;

    pkt_t        mq[$];
    logic [15:0] m_drop, m_mis;

    always #5 clk = ~clk;

    port_egress_buffer #(.PORT_ID(PID), .DEPTH(DEP)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_source    (in_source),
        .in_target    (in_target),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_source   (out_source),
        .out_target   (out_target),
        .out_data     (out_data),
        .level        (level),
        .drop_cnt     (drop_cnt),
        .misroute_cnt (misroute_cnt),
        .clr_cnt      (clr_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        pkt_t h;
        h = (mq.size() > 0) ? mq[0] : '0;
        chk("model out_valid", 32'(out_valid), 32'(mq.size() > 0));
        chk("model out_source", 32'(out_source), 32'(h.src));
        chk("model out_target", 32'(out_target), 32'(h.tgt));
        chk("model out_data", 32'(out_data), 32'(h.dat));
        chk("model level", 32'(level), 32'(mq.size()));
        chk("model drop_cnt", 32'(drop_cnt), 32'(m_drop));
        chk("model misroute_cnt", 32'(misroute_cnt), 32'(m_mis));
    endtask

    // One clock: drive at negedge, advance the model, check just after posedge.
    task automatic step(input logic v, input logic [3:0] s, input logic [3:0] t,
                        input logic [7:0] d, input logic rdy, input logic clr,
                        input logic rst, input bit do_chk);
        bit pop, legal, store;
        @(negedge clk);
        in_valid = v; in_source = s; in_target = t; in_data = d;
        out_ready = rdy; clr_cnt = clr; rst_n = rst;
        if (!rst) begin
            mq.delete();
            m_drop = '0;
            m_mis  = '0;
        end else begin
            pop   = (mq.size() > 0) && rdy;
            legal = v && ($countones(s) == 1) && t[PID] && !s[PID];
            store = legal && ((mq.size() < DEP) || pop);
            if (pop)   void'(mq.pop_front());
            if (store) mq.push_back('{src: s, tgt: t, dat: d});
            if (clr) begin
                m_drop = '0;
                m_mis  = '0;
            end else begin
                if (v && !legal && m_mis != 16'hFFFF)  m_mis++;
                if (legal && !store && m_drop != 16'hFFFF) m_drop++;
            end
        end
        @(posedge clk);
        #1;
        if (do_chk) check_model();
    endtask

    typedef struct {
        logic       v;
        logic [3:0] s, t;
        logic [7:0] d;
        logic       rdy, clr;
        logic       ev;
        logic [4:0] elvl;
        logic [7:0] edat;
        logic [15:0] emis;
    } vec_t;

    vec_t tbl[10];
    logic [7:0] drain_exp[8];

    initial begin
        tbl[0] = '{1'b1, 4'b0001, 4'b0100, 8'hA5, 1'b1, 1'b0, 1'b1, 5'd1, 8'hA5, 16'd0};
        tbl[1] = '{1'b0, 4'b0000, 4'b0000, 8'h00, 1'b1, 1'b0, 1'b0, 5'd0, 8'h00, 16'd0};
        tbl[2] = '{1'b1, 4'b0011, 4'b0100, 8'h11, 1'b1, 1'b0, 1'b0, 5'd0, 8'h00, 16'd1};
        tbl[3] = '{1'b1, 4'b0100, 4'b0100, 8'h22, 1'b1, 1'b0, 1'b0, 5'd0, 8'h00, 16'd2};
        tbl[4] = '{1'b1, 4'b0001, 4'b0010, 8'h33, 1'b1, 1'b0, 1'b0, 5'd0, 8'h00, 16'd3};
        tbl[5] = '{1'b0, 4'b0011, 4'b1111, 8'h44, 1'b1, 1'b0, 1'b0, 5'd0, 8'h00, 16'd3};
        tbl[6] = '{1'b1, 4'b1000, 4'b1111, 8'h3C, 1'b0, 1'b0, 1'b1, 5'd1, 8'h3C, 16'd3};
        tbl[7] = '{1'b1, 4'b0010, 4'b0110, 8'h5A, 1'b0, 1'b0, 1'b1, 5'd2, 8'h3C, 16'd3};
        tbl[8] = '{1'b0, 4'b0000, 4'b0000, 8'h00, 1'b1, 1'b0, 1'b1, 5'd1, 8'h5A, 16'd3};
        tbl[9] = '{1'b0, 4'b0000, 4'b0000, 8'h00, 1'b1, 1'b1, 1'b0, 5'd0, 8'h00, 16'd0};
        drain_exp = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h10, 8'h00};

        rst_n = 1'b0; in_valid = 1'b0; in_source = '0; in_target = '0;
        in_data = '0; out_ready = 1'b0; clr_cnt = 1'b0;
        m_drop = '0; m_mis = '0;

        // Reset with garbage on the inputs
        step(1'b1, 4'b0001, 4'b0100, 8'hEE, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 4'b0001, 4'b0100, 8'hEE, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset level", 32'(level), 32'd0);
        chk("reset out_data", 32'(out_data), 32'd0);

        // Directed table: latency, misroutes, stall, clear
        for (int i = 0; i < 10; i++) begin
            step(tbl[i].v, tbl[i].s, tbl[i].t, tbl[i].d, tbl[i].rdy, tbl[i].clr, 1'b1, 1'b1);
            chk($sformatf("tbl[%0d] out_valid", i), 32'(out_valid), 32'(tbl[i].ev));
            chk($sformatf("tbl[%0d] level", i), 32'(level), 32'(tbl[i].elvl));
            chk($sformatf("tbl[%0d] out_data", i), 32'(out_data), 32'(tbl[i].edat));
            chk($sformatf("tbl[%0d] misroute_cnt", i), 32'(misroute_cnt), 32'(tbl[i].emis));
        end

        // Overfill with consumer stalled, then push+pop while full, then drain
        for (int i = 0; i < 10; i++)
            step(1'b1, 4'b0001, 4'b0100, 8'(i), 1'b0, 1'b0, 1'b1, 1'b1);
        chk("fill level", 32'(level), 32'd8);
        chk("fill drop_cnt", 32'(drop_cnt), 32'd2);
        chk("fill head", 32'(out_data), 32'h00);
        step(1'b1, 4'b0001, 4'b0100, 8'h10, 1'b1, 1'b0, 1'b1, 1'b1);
        chk("full push+pop level", 32'(level), 32'd8);
        chk("full push+pop drop_cnt", 32'(drop_cnt), 32'd2);
        chk("full push+pop head", 32'(out_data), 32'h01);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 4'b0000, 4'b0000, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1);
            chk($sformatf("drain[%0d] data", i), 32'(out_data), 32'(drain_exp[i]));
        end
        chk("drain out_valid", 32'(out_valid), 32'd0);

        // Drop counter saturation and clear-over-increment
        step(1'b0, 4'b0000, 4'b0000, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++)
            step(1'b1, 4'b1000, 4'b0100, 8'(8'h80 + i), 1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 65533; i++)
            step(1'b1, 4'b0001, 4'b0100, 8'hDD, 1'b0, 1'b0, 1'b1, 1'b0);
        check_model();
        chk("sat preset drop_cnt", 32'(drop_cnt), 32'hFFFD);
        step(1'b1, 4'b0001, 4'b0100, 8'hDD, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("sat drop_cnt FFFE", 32'(drop_cnt), 32'hFFFE);
        step(1'b1, 4'b0001, 4'b0100, 8'hDD, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("sat drop_cnt FFFF", 32'(drop_cnt), 32'hFFFF);
        step(1'b1, 4'b0001, 4'b0100, 8'hDD, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("sat drop_cnt hold", 32'(drop_cnt), 32'hFFFF);
        step(1'b1, 4'b0001, 4'b0100, 8'hDD, 1'b0, 1'b1, 1'b1, 1'b1);
        chk("clr over drop", 32'(drop_cnt), 32'd0);
        chk("contents kept on drop", 32'(out_data), 32'h80);

        // Mid-stream reset with level 5
        for (int i = 0; i < 8; i++)
            step(1'b0, 4'b0000, 4'b0000, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++)
            step(1'b1, 4'b0010, 4'b0100, 8'(8'h50 + i), 1'b0, 1'b0, 1'b1, 1'b1);
        chk("pre-reset level", 32'(level), 32'd5);
        step(1'b1, 4'b0010, 4'b0100, 8'h77, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("mid reset level", 32'(level), 32'd0);
        chk("mid reset out_valid", 32'(out_valid), 32'd0);
        step(1'b0, 4'b0000, 4'b0000, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1);
        chk("post reset out_valid", 32'(out_valid), 32'd0);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            logic [3:0] s;
            s = ($urandom_range(0, 3) != 0) ? 4'(1 << $urandom_range(0, 3)) : 4'($urandom);
            step($urandom_range(0, 9) < 7, s, 4'($urandom), 8'($urandom),
                 $urandom_range(0, 1) == 1, $urandom_range(0, 49) == 0,
                 $urandom_range(0, 199) != 0, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
